// File: rtl/vga_timing_ctrl_if.sv
// Pixel/colour/DAC signal bundle between vga_timing_ctrl and its consumers.
// master: the timing controller. slave: the object mux / DAC side.
// Optional macro VGA_TEST_PATTERN_EN adds the testMode select line.
interface vga_timing_ctrl_if;
`ifdef VGA_TEST_PATTERN_EN
  logic        testMode;
`endif
  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_BLANK_N;
  logic [7:0]  oVGA_R;
  logic [7:0]  oVGA_G;
  logic [7:0]  oVGA_B;

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  testMode,
`endif
    input  redIn, greenIn, blueIn,
    output pixelX, pixelY, startOfFrame,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output testMode,
`endif
    output redIn, greenIn, blueIn,
    input  pixelX, pixelY, startOfFrame,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator and DAC output stage.
// Counts pixels/lines, publishes pixelX/pixelY/startOfFrame, delays the region
// flags by PIPE_DELAY clocks so they line up with the colour returned by the
// object mux, then registers sync/blank/RGB onto the DAC pins.
// Optional macro VGA_TEST_PATTERN_EN: adds testMode, which replaces the incoming
// colour on visible pixels by 8 vertical colour bars (80 pixels wide each).
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input logic                clk,
  input logic                resetN,
  vga_timing_ctrl_if.master  vga_io
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        sof_q, sof_d;

  logic active, hs, vs;

  logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic act_dly, hs_dly, vs_dly;

  logic        hs_n_q, vs_n_q, blank_n_q;
  logic [23:0] rgb_q, rgb_d;

  // Pixel/line counters; startOfFrame is registered from the next count so it
  // is high exactly while the current count is the last pixel of the frame.
  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 11'(HTotal - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == 11'(VTotal - 1)) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end
    sof_d = (hcnt_d == 11'(HTotal - 1)) && (vcnt_d == 11'(VTotal - 1));
  end

  // Counter state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      sof_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      sof_q  <= sof_d;
    end
  end

  // Region flags of the coordinate currently presented.
  always_comb begin
    active = (hcnt_q < 11'(H_ACTIVE)) && (vcnt_q < 11'(V_ACTIVE));
    hs     = (hcnt_q >= 11'(H_ACTIVE + H_FP)) && (hcnt_q < 11'(H_ACTIVE + H_FP + H_SYNC));
    vs     = (vcnt_q >= 11'(V_ACTIVE + V_FP)) && (vcnt_q < 11'(V_ACTIVE + V_FP + V_SYNC));
  end

  // Flag delay line: stage 0 takes the live flags, each later stage the previous.
  always_comb begin
    act_pipe_d    = act_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    act_pipe_d[0] = active;
    hs_pipe_d[0]  = hs;
    vs_pipe_d[0]  = vs;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      act_pipe_d[i] = act_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  // Delay line state; reset fills it with blanking so no stale colour escapes.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
    end else begin
      act_pipe_q <= act_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
    end
  end

  assign act_dly = act_pipe_q[PIPE_DELAY-1];
  assign hs_dly  = hs_pipe_q[PIPE_DELAY-1];
  assign vs_dly  = vs_pipe_q[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] x_pipe_q [PIPE_DELAY];
  logic        test_mode_q;
  logic [2:0]  bar;

  // Delayed pixelX (for the bar index) and the registered test-mode select.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        x_pipe_q[i] <= '0;
      end
      test_mode_q <= 1'b0;
    end else begin
      x_pipe_q[0] <= hcnt_q;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        x_pipe_q[i] <= x_pipe_q[i-1];
      end
      test_mode_q <= vga_io.testMode;
    end
  end

  // Only meaningful on visible pixels, where x < 640 keeps the index in 0..7.
  assign bar = 3'(x_pipe_q[PIPE_DELAY-1] / 11'd80);
`endif

  // Colour selection: blanked outside the visible area.
  always_comb begin
    rgb_d = '0;
    if (act_dly) begin
      rgb_d = {vga_io.redIn, vga_io.greenIn, vga_io.blueIn};
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode_q) begin
        rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      end
`endif
    end
  end

  // DAC output register; syncs are active low, idle high in reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_n_q    <= ~hs_dly;
      vs_n_q    <= ~vs_dly;
      blank_n_q <= act_dly;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_io.pixelX       = hcnt_q;
  assign vga_io.pixelY       = vcnt_q;
  assign vga_io.startOfFrame = sof_q;
  assign vga_io.oVGA_HS      = hs_n_q;
  assign vga_io.oVGA_VS      = vs_n_q;
  assign vga_io.oVGA_BLANK_N = blank_n_q;
  assign vga_io.oVGA_R       = rgb_q[23:16];
  assign vga_io.oVGA_G       = rgb_q[15:8];
  assign vga_io.oVGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. Horizontal timing is the full 800-clock line; the
// vertical timing is shortened (21 lines) so two whole frames plus a mid-frame
// reset fit a short run. Expected pins come from a cycle-indexed model: the pin
// state at cycle t belongs to coordinate t-PIPE_DELAY-1 and carries the colour
// that was driven during cycle t-1.
module tb_vga_timing_ctrl;
  localparam int PD    = 2;
  localparam int HA    = 640;
  localparam int HFP   = 16;
  localparam int HSY   = 96;
  localparam int HT    = 800;
  localparam int VA    = 12;
  localparam int VFP   = 3;
  localparam int VSY   = 2;
  localparam int VBP   = 4;
  localparam int VT    = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #20 clk = ~clk;

  vga_timing_ctrl_if vif ();

  vga_timing_ctrl #(
    .H_ACTIVE   (HA),
    .H_FP       (HFP),
    .H_SYNC     (HSY),
    .H_BP       (48),
    .V_ACTIVE   (VA),
    .V_FP       (VFP),
    .V_SYNC     (VSY),
    .V_BP       (VBP),
    .PIPE_DELAY (PD)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .vga_io (vif)
  );

  int          t;
  int          n_total = 0;
  int          n_bad = 0;
  int          last_sof = -1;
  int          vs_run = 0;
  int          hs_run = 0;
  logic [23:0] col_hist [8];
  logic        tm_hist [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Colour for cycle t: random, all-white or pixelX-tracking, rotating per line.
  task automatic drive();
    logic [23:0] c;
    logic        tm;
    int          m;
    m = (t / HT) % 3;
    c = 24'($urandom);
    if (m == 1) c = 24'hFFFFFF;
    if (m == 2) c[23:16] = (t >= PD) ? 8'((t - PD) % HT) : 8'h00;
    tm = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    tm = ((t / HT) % 4) == 3;
    vif.testMode = tm;
`endif
    vif.redIn   = c[23:16];
    vif.greenIn = c[15:8];
    vif.blueIn  = c[7:0];
    col_hist[t % 8] = c;
    tm_hist[t % 8]  = tm;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_x"}, 32'(vif.pixelX), 0);
    chk({pfx, "_y"}, 32'(vif.pixelY), 0);
    chk({pfx, "_sof"}, 32'(vif.startOfFrame), 0);
    chk({pfx, "_hs"}, 32'(vif.oVGA_HS), 1);
    chk({pfx, "_vs"}, 32'(vif.oVGA_VS), 1);
    chk({pfx, "_blank"}, 32'(vif.oVGA_BLANK_N), 0);
    chk({pfx, "_rgb"}, {8'h0, vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}, 0);
  endtask

  task automatic check_cycle();
    int          u, x, y, ux, uy, k;
    logic        act, e_hs, e_vs;
    logic [23:0] e_rgb;
    x = t % HT;
    y = (t / HT) % VT;
    chk("pixelX", 32'(vif.pixelX), 32'(x));
    chk("pixelY", 32'(vif.pixelY), 32'(y));
    chk("sof", 32'(vif.startOfFrame), 32'((x == HT - 1) && (y == VT - 1)));
    u     = t - PD - 1;
    act   = 1'b0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_rgb = '0;
    if (u >= 0) begin
      ux   = u % HT;
      uy   = (u / HT) % VT;
      act  = (ux < HA) && (uy < VA);
      e_hs = !((ux >= HA + HFP) && (ux < HA + HFP + HSY));
      e_vs = !((uy >= VA + VFP) && (uy < VA + VFP + VSY));
      if (act) begin
        e_rgb = col_hist[(t - 1) % 8];
        if (tm_hist[(t - 2) % 8]) begin
          k     = ux / 80;
          e_rgb = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
        end
      end
    end
    chk("hs_n", 32'(vif.oVGA_HS), 32'(e_hs));
    chk("vs_n", 32'(vif.oVGA_VS), 32'(e_vs));
    chk("blank_n", 32'(vif.oVGA_BLANK_N), 32'(act));
    chk("rgb", {8'h0, vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}, {8'h0, e_rgb});
    // Whole-pulse properties: frame period and sync pulse widths.
    if (vif.startOfFrame) begin
      if (last_sof >= 0) chk("sof_period", 32'(t - last_sof), 32'(FRAME));
      else chk("sof_first", 32'(t), 32'(FRAME - 1));
      last_sof = t;
    end
    if (!vif.oVGA_VS) vs_run++;
    else if (vs_run > 0) begin
      chk("vs_low_len", 32'(vs_run), 32'(VSY * HT));
      vs_run = 0;
    end
    if (!vif.oVGA_HS) hs_run++;
    else if (hs_run > 0) begin
      chk("hs_low_len", 32'(hs_run), 32'(HSY));
      hs_run = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      t++;
      drive();
    end
  endtask

  initial begin
    t = 0;
    for (int i = 0; i < 8; i++) begin
      col_hist[i] = '0;
      tm_hist[i]  = 1'b0;
    end
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_init");
    @(posedge clk);
    #1;
    resetN = 1'b1;
    t = 0;
    drive();

    // Two full frames, then on to line 5, pixel 300 of the third.
    run_cycles(2 * FRAME + 5 * HT + 300);
    chk("pre_rst_x", 32'(vif.pixelX), 300);

    // Asynchronous reset mid-cycle: values must change with no clock edge.
    #5;
    resetN = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1;
    resetN   = 1'b1;
    t        = 0;
    last_sof = -1;
    vs_run   = 0;
    hs_run   = 0;
    drive();

    // Restart from (0,0); first startOfFrame only at the end of this frame.
    run_cycles(FRAME + HT);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
